// File: rtl/seven_seg_pkg.sv
// Shared defaults and limits for the multiplexed seven-segment scanner.
package seven_seg_pkg;

  localparam int unsigned DIGIT_W_DEF      = 4;
  localparam int unsigned REFRESH_DIV_DEF  = 48000;
  localparam int unsigned BLANK_CYCLES_DEF = 1000;
  localparam int unsigned MAX_DIGITS       = 8;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Digit data in, scan position and anode/segment drive out.
interface seven_seg_scan_if
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned DIGIT_W    = DIGIT_W_DEF
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
  logic [NUM_DIGITS-1:0]         digit_en;
  logic                          hold;
  logic [DIGIT_W-1:0]            seg_val;
  logic [NUM_DIGITS-1:0]         anode_n;
  logic [IDX_W-1:0]              digit_idx;
  logic                          slot_tick;

  modport master (
    output digits_in, digit_en, hold,
    input  seg_val, anode_n, digit_idx, slot_tick
  );

  modport slave (
    input  digits_in, digit_en, hold,
    output seg_val, anode_n, digit_idx, slot_tick
  );

endinterface

// File: rtl/seven_seg_scan_divider.sv
// Slot counter with hold; slot_end marks the terminal count of a running slot.
// cnt_next is exported only when SEVEN_SEG_SCAN_BLANK_EN is defined.
module scan_divider
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEF,
  localparam int unsigned CNT_W      = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  output logic             slot_end
`ifdef SEVEN_SEG_SCAN_BLANK_EN
  ,
  output logic [CNT_W-1:0] cnt_next
`endif
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Hold wins over a coincident terminal count, so the slot never ends while frozen.
  always_comb begin
    slot_end = !hold && (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d    = cnt_q;
    if (!hold) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef SEVEN_SEG_SCAN_BLANK_EN
  assign cnt_next = cnt_d;
`endif

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed digit scanner: rotates the active digit each slot and drives anodes/value.
// Optional ghosting suppression under SEVEN_SEG_SCAN_BLANK_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned DIGIT_W      = DIGIT_W_DEF,
  parameter int unsigned REFRESH_DIV  = REFRESH_DIV_DEF,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
`ifdef SEVEN_SEG_SCAN_BLANK_EN
  localparam bit          BLANK_EN = 1'b1;
  localparam int unsigned CNT_W    = $clog2(REFRESH_DIV);
`else
  localparam bit          BLANK_EN = 1'b0;
`endif

  generate
    if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
      $fatal(1, "seven_seg_scan: NUM_DIGITS must be 2..%0d", MAX_DIGITS);
    end
    if (DIGIT_W < 1) begin : g_bad_digit_w
      $fatal(1, "seven_seg_scan: DIGIT_W must be >= 1");
    end
    if (REFRESH_DIV < 4) begin : g_bad_refresh_div
      $fatal(1, "seven_seg_scan: REFRESH_DIV must be >= 4");
    end
    if (BLANK_EN && (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV)) begin : g_bad_blank
      $fatal(1, "seven_seg_scan: BLANK_CYCLES must be 1..REFRESH_DIV-1");
    end
  endgenerate

  logic                  slot_end;
  logic                  blank;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tick_q;
  logic [DIGIT_W-1:0]    seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
`ifdef SEVEN_SEG_SCAN_BLANK_EN
  logic [CNT_W-1:0]      cnt_next;
`endif

  scan_divider #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .hold     (bus.hold),
    .slot_end (slot_end)
`ifdef SEVEN_SEG_SCAN_BLANK_EN
    ,
    .cnt_next (cnt_next)
`endif
  );

  always_comb begin
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Blank on the count the anode register will be seen alongside, i.e. the next count.
`ifdef SEVEN_SEG_SCAN_BLANK_EN
  assign blank = (cnt_next < CNT_W'(BLANK_CYCLES));
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d   = '0;
    anode_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        seg_d = bus.digits_in[k*DIGIT_W +: DIGIT_W];
        if (bus.digit_en[k] && !blank) begin
          anode_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      tick_q  <= 1'b0;
      seg_q   <= '0;
      anode_q <= '1;
    end else begin
      idx_q   <= idx_d;
      tick_q  <= slot_end;
      seg_q   <= seg_d;
      anode_q <= anode_d;
    end
  end

  assign bus.digit_idx = idx_q;
  assign bus.slot_tick = tick_q;
  assign bus.seg_val   = seg_q;
  assign bus.anode_n   = anode_q;

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2, number of multiplexed digits, legal 2..8.
REQ-002 SHALL have parameter DIGIT_W, default 4, bits per digit value.
REQ-003 SHALL have parameter REFRESH_DIV, default 48000, clk cycles per digit slot, legal >= 4.
REQ-004 SHALL have parameter BLANK_CYCLES, default 1000, blanking cycles at the start of each slot, legal 1..REFRESH_DIV-1; used only with SEVEN_SEG_SCAN_BLANK_EN.
REQ-005 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port digits_in  in  NUM_DIGITS*DIGIT_W  digit values, digit k at bits [k*DIGIT_W +: DIGIT_W].
REQ-008 SHALL have port digit_en  in  NUM_DIGITS  per-digit display enable mask.
REQ-009 SHALL have port hold  in  1  freezes the scan position while high.
REQ-010 SHALL have port seg_val  out  DIGIT_W  value of the active digit, to the seven-segment decoder.
REQ-011 SHALL have port anode_n  out  NUM_DIGITS  active-low digit drive, at most one bit low.
REQ-012 SHALL have port digit_idx  out  $clog2(NUM_DIGITS)  index of the active digit.
REQ-013 SHALL have port slot_tick  out  1  one-cycle pulse on each digit change.

Function
REQ-014 SHALL count a slot counter 0..REFRESH_DIV-1 and wrap to 0; the terminal count is the slot end.
REQ-015 SHALL advance digit_idx by 1 at each slot end and wrap from NUM_DIGITS-1 to 0.
REQ-016 SHALL assert slot_tick for exactly the cycle in which the new digit_idx value first appears.
REQ-017 SHALL freeze the slot counter and digit_idx while hold=1, keep slot_tick at 0, and resume from the frozen count when hold falls.
REQ-018 SHALL register seg_val as digits_in slice[digit_idx], with 1-cycle latency from digits_in or digit_idx change, including during hold.
REQ-019 SHALL register anode_n so that bit digit_idx is low only if digit_en[digit_idx]=1 (and not blanking); all other bits are high.
REQ-020 SHALL keep anode_n all-ones with the scan running when digit_en is all zeros.
REQ-021 SHALL apply a digit_en change to anode_n 1 cycle later, without restarting the slot.
REQ-022 SHALL let a slot end coincident with hold rising be suppressed: hold takes priority and the index does not advance.

Reset
REQ-023 SHALL, while reset=0 and asynchronously, force slot counter=0, digit_idx=0, seg_val=0, anode_n all-ones, and slot_tick=0.
REQ-024 SHALL restart from slot 0, count 0, after a reset asserted mid-slot, with no partial tick.
REQ-025 SHALL, on the first clk after reset releases, drive seg_val and anode_n for digit 0.

Configuration
REQ-026 SHALL, when macro SEVEN_SEG_SCAN_BLANK_EN is defined, force anode_n all-ones for slot counts 0..BLANK_CYCLES-1 of every slot (ghosting suppression); seg_val still updates.
REQ-027 SHALL, when SEVEN_SEG_SCAN_BLANK_EN is undefined, have no blanking, ignore BLANK_CYCLES, and add no blanking logic.

Structure
REQ-028 SHALL place DIGIT_W default, REFRESH_DIV default, BLANK_CYCLES default, and the max NUM_DIGITS constant in package seven_seg_pkg.
REQ-029 SHALL implement the slot counter, hold, and terminal-count pulse in sub-module scan_divider; seven_seg_scan owns the index, mux, and anode logic.
REQ-030 SHALL check parameter legality at elaboration with a fatal error.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 unless noted)
REQ-031 SHALL cover: reset release, digits_in=16'h4321, digit_en=4'hF -> digit_idx cycles 0,1,2,3,0 every 4 clk; seg_val 1,2,3,4; anode_n E,D,B,7; slot_tick once per slot.
REQ-032 SHALL cover: hold=1 for 10 clk at count 2 of digit 1 -> digit_idx stays 1, no slot_tick, digit 2 begins 2 clk after hold falls.
REQ-033 SHALL cover: digit_en=4'b0101 -> anode_n F during slots 1 and 3, E in slot 0, B in slot 2; index still advances.
REQ-034 SHALL cover: reset pulsed low mid-slot of digit 2 -> outputs immediately at reset values, then restart at digit 0.
REQ-035 SHALL cover: with SEVEN_SEG_SCAN_BLANK_EN, anode_n=F at count 0 of every slot; without the macro, never F while digit_en=F.
REQ-036 SHALL cover: digits_in changed mid-slot -> seg_val follows after exactly 1 clk.
